// File: rtl/sync_arm_pkg.sv
// Shared types and constants for the sync arm generator.
// The optional PPS drift check is enabled with SYNC_ARM_PPS_CHECK_EN.
package sync_arm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int ARM_BIT      = 0;
  localparam int FORCE_BIT    = 1;
  localparam int PERIODIC_BIT = 2;
  localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/sync_arm_if.sv
// Control/status bundle between software regs and sync_arm_gen.
// err_count exists only when SYNC_ARM_PPS_CHECK_EN is defined.
interface sync_arm_if #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 16
);

  logic [31:0]         ctrl_word;
  logic                ext_sync_in;
  logic [PERIOD_W-1:0] period;
  logic                sync_out;
  logic                armed;
  logic                running;
  logic [CNT_W-1:0]    sync_count;

`ifdef SYNC_ARM_PPS_CHECK_EN
  logic [7:0]          err_count;

  modport master (
    output ctrl_word, ext_sync_in, period,
    input  sync_out, armed, running, sync_count, err_count
  );

  modport slave (
    input  ctrl_word, ext_sync_in, period,
    output sync_out, armed, running, sync_count, err_count
  );
`else
  modport master (
    output ctrl_word, ext_sync_in, period,
    input  sync_out, armed, running, sync_count
  );

  modport slave (
    input  ctrl_word, ext_sync_in, period,
    output sync_out, armed, running, sync_count
  );
`endif

endinterface

// File: rtl/sync_arm_gen_edge_det.sv
// Synchronizer plus history flop producing a registered rising-edge
// pulse for an asynchronous input.
module sync_edge_det
  import sync_arm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;
  logic                  pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_DEPTH-2:0], d};
    hist_d  = sync_q[SYNC_DEPTH-1];
    pulse_d = sync_q[SYNC_DEPTH-1] & ~hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/sync_arm_gen.sv
// Arm-then-fire sync pulse generator with optional periodic re-sync.
// SYNC_ARM_PPS_CHECK_EN adds err_count for external sync drift.
module sync_arm_gen
  import sync_arm_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic     user_clk,
  input  logic     user_rst,
  sync_arm_if.slave bus
);

  logic [2:0]          ctrl_q, ctrl_d;
  logic [2:0]          prev_q, prev_d;
  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                sync_out_q, sync_out_d;

  logic                ext_edge;
  logic                arm_req;
  logic                force_req;
  logic                per_en;
  logic                fire;
  logic [PERIOD_W-1:0] reload;
  logic [28:0]         unused_ctrl;

  assign unused_ctrl = bus.ctrl_word[31:3];

  sync_edge_det u_ext_det (
    .clk   (user_clk),
    .rst   (user_rst),
    .d     (bus.ext_sync_in),
    .pulse (ext_edge)
  );

  always_comb begin
    ctrl_d = bus.ctrl_word[2:0];
    prev_d = ctrl_q;
  end

  assign arm_req   = ctrl_q[ARM_BIT] & ~prev_q[ARM_BIT];
  assign force_req = ctrl_q[FORCE_BIT] & ~prev_q[FORCE_BIT];
  assign per_en    = ctrl_q[PERIODIC_BIT];

  // Period 0 behaves like 1 rather than wrapping to a huge interval.
  assign reload = (bus.period == '0) ? '0
                : bus.period - PERIOD_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    sync_out_d = 1'b0;
    fire       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm_req) begin
          state_d = ARMED;
          count_d = '0;
        end
      end
      ARMED: begin
        if (ext_edge | force_req) begin
          fire    = 1'b1;
          cnt_d   = reload;
          state_d = (per_en && bus.period >= PERIOD_W'(2))
                  ? RUN : IDLE;
        end
      end
      RUN: begin
        if (arm_req) begin
          state_d = ARMED;
          count_d = '0;
        end else if (!per_en) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          fire  = 1'b1;
          cnt_d = reload;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      sync_out_d = 1'b1;
      count_d    = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ctrl_q     <= '0;
      prev_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      count_q    <= '0;
      sync_out_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      sync_out_q <= sync_out_d;
    end
  end

  assign bus.sync_out   = sync_out_q;
  assign bus.armed      = (state_q == ARMED);
  assign bus.running    = (state_q == RUN);
  assign bus.sync_count = count_q;

`ifdef SYNC_ARM_PPS_CHECK_EN
  logic [7:0] err_q, err_d;

  // An external edge away from the counter wrap means drift.
  always_comb begin
    err_d = err_q;
    if (arm_req) begin
      err_d = '0;
    end else if (state_q == RUN && ext_edge &&
                 cnt_q != '0 && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) err_q <= '0;
    else          err_q <= err_d;
  end

  assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_sync_arm_gen.sv
// Bench for sync_arm_gen: vector table, directed sequences and a
// random run against a time-stamp based reference model.
module tb_sync_arm_gen;

  logic clk = 1'b0;
  logic user_rst = 1'b0;

  always #5 clk = ~clk;

  sync_arm_if #(.PERIOD_W(32), .CNT_W(16)) bus ();

  sync_arm_gen #(.PERIOD_W(32), .CNT_W(16)) dut (
    .user_clk (clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  typedef struct {
    logic [2:0]  cw;
    logic        e;
    logic [18:0] exp;
  } vec_t;

  localparam int MAXC = 8192;

  vec_t        tbl [30];
  logic [2:0]  c_h [MAXC];
  logic        d_h [MAXC];
  logic [31:0] p_h [MAXC];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  int          m_mode;
  int          m_next;
  logic [15:0] m_count;
  logic        m_sync;
  int          m_err;

  task automatic chk(input string nm, input longint got,
                     input longint want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [18:0] dut_main();
    return {bus.sync_out, bus.armed, bus.running, bus.sync_count};
  endfunction

  function automatic longint dut_vec();
`ifdef SYNC_ARM_PPS_CHECK_EN
    return longint'({dut_main(), bus.err_count});
`else
    return longint'(dut_main());
`endif
  endfunction

  function automatic longint mdl_vec();
    logic [18:0] v;
    v = {m_sync, m_mode == 1, m_mode == 2, m_count};
`ifdef SYNC_ARM_PPS_CHECK_EN
    return longint'({v, 8'(m_err)});
`else
    return longint'(v);
`endif
  endfunction

  function automatic logic [2:0] hc(int i);
    return (i < 0) ? 3'd0 : c_h[i];
  endfunction

  function automatic logic hd(int i);
    return (i < 0) ? 1'b0 : d_h[i];
  endfunction

  // Decision at clock edge t, from the input values sampled at each edge.
  task automatic model_step(input int t);
    logic [2:0] c1, c2;
    logic arm, frc, pen, ext, fire;
    int p;
    c1   = hc(t - 1);
    c2   = hc(t - 2);
    arm  = c1[0] & ~c2[0];
    frc  = c1[1] & ~c2[1];
    pen  = c1[2];
    ext  = hd(t - 3) & ~hd(t - 4);
    p    = int'(p_h[t]);
    fire = 1'b0;
    if (arm) m_err = 0;
    else if (m_mode == 2 && ext && t != m_next && m_err < 255)
      m_err++;
    case (m_mode)
      0: if (arm) begin m_mode = 1; m_count = 0; end
      1: if (ext || frc) begin
        fire = 1'b1;
        if (pen && p >= 2) begin m_mode = 2; m_next = t + p; end
        else m_mode = 0;
      end
      default: begin
        if (arm) begin m_mode = 1; m_count = 0; end
        else if (!pen) m_mode = 0;
        else if (t == m_next) begin
          fire = 1'b1;
          m_next = t + ((p == 0) ? 1 : p);
        end
      end
    endcase
    m_sync = fire;
    if (fire) m_count = m_count + 16'd1;
  endtask

  task automatic mtick(input logic [31:0] cw, input logic e,
                       input logic [31:0] per);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL history overflow at cyc=%0d", cyc);
      $fatal(1);
    end
    c_h[cyc] = cw[2:0];
    d_h[cyc] = e;
    p_h[cyc] = per;
    bus.ctrl_word   = cw;
    bus.ext_sync_in = e;
    bus.period      = per;
    @(posedge clk);
    #1;
    model_step(cyc);
    chk($sformatf("model@%0d", cyc), dut_vec(), mdl_vec());
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    #1;
    chk("rst_async", dut_vec(), 0);
    for (int i = 0; i < 4; i++) begin
      bus.ext_sync_in = ~bus.ext_sync_in;
      bus.ctrl_word   = 32'h7;
      bus.period      = 32'd5;
      @(posedge clk);
      #1;
      chk("rst_hold", dut_vec(), 0);
    end
    bus.ctrl_word   = '0;
    bus.ext_sync_in = 1'b0;
    bus.period      = '0;
    user_rst = 1'b0;
    cyc      = -1;
    m_mode   = 0;
    m_next   = 0;
    m_count  = '0;
    m_sync   = 1'b0;
    m_err    = 0;
  endtask

  task automatic row(input int i, input int cw, input int e,
                     input int so, input int a, input int r,
                     input int n);
    tbl[i].cw  = 3'(cw);
    tbl[i].e   = 1'(e);
    tbl[i].exp = {1'(so), 1'(a), 1'(r), 16'(n)};
  endtask

  initial begin
    int q_pulses [$];
    int n;
    int t_ext;
    logic [31:0] cw, per;
    logic e;

    row( 0, 1, 0, 0, 0, 0, 0);  row( 1, 1, 0, 0, 1, 0, 0);
    row( 2, 1, 1, 0, 1, 0, 0);  row( 3, 1, 1, 0, 1, 0, 0);
    row( 4, 1, 0, 0, 1, 0, 0);  row( 5, 1, 0, 1, 0, 0, 1);
    row( 6, 1, 1, 0, 0, 0, 1);  row( 7, 1, 0, 0, 0, 0, 1);
    row( 8, 1, 0, 0, 0, 0, 1);  row( 9, 1, 0, 0, 0, 0, 1);
    row(10, 0, 0, 0, 0, 0, 1);  row(11, 1, 0, 0, 0, 0, 1);
    row(12, 1, 0, 0, 1, 0, 0);  row(13, 3, 1, 0, 1, 0, 0);
    row(14, 3, 0, 1, 0, 0, 1);  row(15, 3, 0, 0, 0, 0, 1);
    row(16, 3, 0, 0, 0, 0, 1);  row(17, 0, 0, 0, 0, 0, 1);
    row(18, 1, 0, 0, 0, 0, 1);  row(19, 1, 1, 0, 1, 0, 0);
    row(20, 1, 0, 0, 1, 0, 0);  row(21, 3, 0, 0, 1, 0, 0);
    row(22, 3, 0, 1, 0, 0, 1);  row(23, 3, 0, 0, 0, 0, 1);
    row(24, 3, 1, 0, 0, 0, 1);  row(25, 0, 0, 0, 0, 0, 1);
    row(26, 1, 0, 0, 0, 0, 1);  row(27, 1, 0, 0, 1, 0, 0);
    row(28, 1, 0, 0, 1, 0, 0);  row(29, 1, 0, 0, 1, 0, 0);

    bus.ctrl_word   = '0;
    bus.ext_sync_in = 1'b0;
    bus.period      = '0;
    #2;
    do_reset();

    for (int i = 0; i < 30; i++) begin
      bus.ctrl_word   = 32'(tbl[i].cw);
      bus.ext_sync_in = tbl[i].e;
      bus.period      = '0;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d", i), longint'(dut_main()),
          longint'(tbl[i].exp));
    end

    // Reset while ARMED; then periodic run with period 100.
    do_reset();
    mtick(32'h0, 1'b0, 32'd100);
    mtick(32'h5, 1'b0, 32'd100);
    mtick(32'h5, 1'b0, 32'd100);
    mtick(32'h5, 1'b0, 32'd100);
    chk("per_armed", longint'(bus.armed), 1);
    mtick(32'h5, 1'b1, 32'd100);
    t_ext = cyc;
    for (int i = 0; i < 700 && q_pulses.size() < 5; i++) begin
      mtick(32'h5, 1'b0, 32'd100);
      if (bus.sync_out) q_pulses.push_back(cyc);
    end
    chk("per_npulses", longint'(q_pulses.size()), 5);
    if (q_pulses.size() == 5) begin
      chk("per_first", longint'(q_pulses[0] - t_ext), 3);
      for (int i = 1; i < 5; i++)
        chk($sformatf("per_gap%0d", i),
            longint'(q_pulses[i] - q_pulses[i-1]), 100);
    end
    chk("per_count", longint'(bus.sync_count), 5);
    chk("per_running", longint'(bus.running), 1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      mtick(32'h1, 1'b0, 32'd100);
      n += int'(bus.sync_out);
    end
    chk("per_stop_pulses", longint'(n), 0);
    chk("per_stop_running", longint'(bus.running), 0);

    // Level-held arm with repeated external edges fires once.
    do_reset();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      mtick(32'h1, 1'b0 | ((i % 37) == 5), 32'd20);
      n += int'(bus.sync_out);
    end
    chk("hold_pulses", longint'(n), 1);
    mtick(32'h0, 1'b0, 32'd20);
    mtick(32'h1, 1'b0, 32'd20);
    mtick(32'h1, 1'b0, 32'd20);
    chk("rearm", longint'(bus.armed), 1);

    // Random stimulus against the model.
    do_reset();
    cw  = '0;
    per = 32'd8;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 20 == 0) cw = $urandom;
      if ($urandom % 60 == 0) per = 32'($urandom_range(0, 14));
      e = ($urandom % 6 == 0);
      mtick(cw, e, per);
    end

`ifdef SYNC_ARM_PPS_CHECK_EN
    do_reset();
    mtick(32'h0, 1'b0, 32'd10);
    for (int i = 0; i < 3; i++) mtick(32'h5, 1'b0, 32'd10);
    for (int i = 0; i < 3600; i++)
      mtick(32'h5, 1'b0 | ((i % 11) == 0), 32'd10);
    chk("err_sat", longint'(bus.err_count), 255);
    mtick(32'h4, 1'b0, 32'd10);
    mtick(32'h5, 1'b0, 32'd10);
    mtick(32'h5, 1'b0, 32'd10);
    chk("err_clr", longint'(bus.err_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
